lnrv_plmt_mc: RTL
=================

# lnrv_plmt_mc

Multi-channel platform machine timer: one free-running CNT_W-bit `mtime` counter with a programmable prescaler, and NCH independent compare channels. Each channel raises its own interrupt in either RISC-V level mode or periodic auto-reload mode. The block sits on the peripheral APB bus next to the other `lnrv` perips and drives per-channel interrupt request/acknowledge pairs into the interrupt controller. It generalises the single-comparator machine timer to N channels, a configurable counter width and periodic operation.

## Interface
- NCH, 2, number of compare channels, 1..8
- CNT_W, 64, width of `mtime` and each compare register, 33..64
- PSC_W, 8, prescaler divider width, 1..16
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- psel  in  1  APB select
- penable  in  1  APB access phase
- pwrite  in  1  APB write
- paddr  in  8  APB byte address, word aligned
- pwdata  in  32  APB write data
- prdata  out  32  APB read data
- pslverr  out  1  APB error
- pready  out  1  APB ready, tied 1
- irq_req  out  NCH  per-channel interrupt request
- irq_ack  in  NCH  per-channel acknowledge pulse

## Operation
- Register map; upper unused bits read 0; HI registers expose bits [CNT_W-1:32]:
  - 0x00 CTRL: [0] EN, [1] CLR (write-1, self-clearing, reads 0), [PSC_W+7:8] DIV
  - 0x04 MTIME_LO, 0x08 MTIME_HI (reads return the shadow)
  - 0x0C IRQ_STAT: [NCH-1:0] pending, W1C
  - 0x10+0x10*i, channel i: +0 CMP_LO, +4 CMP_HI, +8 CH_CTRL ([0] IEN, [1] PERIODIC), +C PERIOD (32-bit)
- pslverr=1 in access phase for unmapped addresses or channel index ≥ NCH. Erroring writes have no effect. Erroring reads return 0.
- Prescaler: counter `psc` counts 0..DIV; `tick` = EN & (psc==DIV). DIV=0 gives a tick every cycle. `psc` holds at 0 while EN=0.
- On tick, `mtime` <= `mtime`+1, wrapping modulo 2^CNT_W.
- Reading MTIME_LO captures `mtime`[CNT_W-1:32] into the shadow in the same cycle, so a LO-then-HI read pair is coherent.
- `match[i]` = (`mtime` >= CMP[i]), unsigned, computed from register outputs.
- Level mode (PERIODIC=0):
  - pending[i] <= IEN & `match[i]` every cycle; irq_ack is ignored.
  - Writing CMP above `mtime` clears the request on the next cycle.
- Periodic mode (PERIODIC=1):
  - When IEN & `match[i]`: pending[i] <= 1 and CMP[i] <= CMP[i]+PERIOD, modulo 2^CNT_W.
  - irq_ack[i] or a W1C write clears pending[i].
- irq_req = pending, as a registered output.
- Precedence, highest first:
  - `mtime`: reset > CLR > APB write > tick.
  - CMP[i]: reset > APB write > auto-reload.
  - pending[i]: reset > set by match > clear by ack/W1C.
- PERIOD=0 in periodic mode leaves CMP unchanged, so pending re-sets every cycle while matching.
- Clearing IEN stops new sets but does not clear an already pending bit in periodic mode.
- Reset values:
  - `mtime`=0, shadow=0, `psc`=0, CTRL=0.
  - CMP=all ones, CH_CTRL=0, PERIOD=0, pending=0.
  - irq_req=0, prdata=0, pslverr=0, pready=1.

## Timing
- APB is zero wait-state:
  - Setup phase: psel=1, penable=0.
  - Access phase: psel=1, penable=1, one cycle.
  - Writes commit at the clock edge ending the access phase.
  - prdata and pslverr are valid combinationally during the access phase; prdata=0 outside it.
- Match to irq_req: 1 cycle. `mtime` reaching CMP at edge N gives irq_req=1 after edge N+1.
- Periodic auto-reload: CMP updates at the same edge that sets pending.
- irq_ack sampled high at edge N gives irq_req=0 after edge N, unless a new match occurs in that cycle.
- CMP or CTRL write committed at edge N affects match and irq_req from edge N+1.
- A reset asserted mid-transfer aborts it; the first valid transfer follows reset deassertion.

## Test plan
- Reset, then read all registers:
  - CMP_LO/HI=0xFFFFFFFF, others 0, irq_req=0, pready=1.
  - Read 0x90 with NCH=2 gives pslverr=1 and prdata=0.
- Prescaler:
  - DIV=3, EN=1, run 40 cycles: MTIME_LO=10.
  - Set CLR while running: `mtime`=0 next cycle.
  - Write MTIME_LO=0xFFFFFFFF, MTIME_HI=0, DIV=0, then read LO then HI: carry is visible in the HI read without tearing.
- Level mode, channel 0:
  - CMP=20, IEN=1: irq_req[0] rises 1 cycle after `mtime`=20.
  - irq_ack has no effect.
  - Write CMP=1000: irq_req[0] falls the next cycle.
- Periodic mode, channel 1:
  - CMP=10, PERIOD=5, DIV=0: pending sets at `mtime`=10, 15, 20…; CMP reads 15, 20, 25.
  - irq_ack clears the request each time.
  - Ack coincident with a new match keeps irq_req=1.
- Simultaneous events:
  - APB write to CMP coinciding with auto-reload: the written value wins.
  - W1C of IRQ_STAT in the same cycle as a match: the bit stays 1.
- Wrap:
  - CNT_W=40, `mtime`=2^40-2, CMP=2^40-1, PERIOD=4, periodic mode: CMP wraps to 3 and `mtime` wraps to 0.
  - The next interrupt fires at `mtime`=3.

Source files
------------

// File: rtl/lnrv_plmt_mc.sv
// lnrv_plmt_mc: multi-channel platform machine timer.
// One free-running mtime counter behind a programmable prescaler, plus NCH
// compare channels, each raising its own interrupt in RISC-V level mode or
// in periodic auto-reload mode. Registers sit on a zero wait-state APB port.
//
// APB handshake: a transfer is the access phase (psel & penable). pready is
// tied high, so every access phase completes in that single cycle. Writes
// commit at the clock edge that ends the access phase. prdata/pslverr are
// combinational during the access phase, and prdata is 0 at all other times.
module lnrv_plmt_mc #(
  parameter int NCH   = 2,
  parameter int CNT_W = 64,
  parameter int PSC_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             psel,
  input  logic             penable,
  input  logic             pwrite,
  input  logic [7:0]       paddr,
  input  logic [31:0]      pwdata,
  output logic [31:0]      prdata,
  output logic             pslverr,
  output logic             pready,
  output logic [NCH-1:0]   irq_req,
  input  logic [NCH-1:0]   irq_ack
);

  localparam int HI_W = CNT_W - 32;
  localparam logic [3:0]       NCH_L   = 4'(NCH);
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [PSC_W-1:0] PSC_ONE = {{(PSC_W-1){1'b0}}, 1'b1};

  // Timer state
  logic             ctrl_en;
  logic [PSC_W-1:0] ctrl_div;
  logic [PSC_W-1:0] psc;
  logic             tick;
  logic [CNT_W-1:0] mtime;
  logic [HI_W-1:0]  shadow;

  // Channel state
  logic [CNT_W-1:0] cmp    [NCH];
  logic [31:0]      period [NCH];
  logic [NCH-1:0]   ien;
  logic [NCH-1:0]   periodic;
  logic [NCH-1:0]   pending;
  logic [NCH-1:0]   match;

  // Address decode: block 0 is the global registers, block i+1 is channel i
  logic [3:0]  blk;
  logic [1:0]  word;
  logic [3:0]  ch_sel;
  logic        ch_ok;
  logic        addr_err;
  logic        access;
  logic        wr;
  logic        rd;
  logic        wr_ctrl;
  logic        wr_mlo;
  logic        wr_mhi;
  logic        wr_stat;
  logic        rd_mlo;
  logic [31:0] rd_data;
  logic        unused_addr;

  assign blk         = paddr[7:4];
  assign word        = paddr[3:2];
  assign ch_sel      = blk - 4'd1;
  assign ch_ok       = (blk != 4'd0) && (ch_sel < NCH_L);
  assign addr_err    = (blk != 4'd0) && !ch_ok;
  assign access      = psel & penable;
  assign wr          = access & pwrite & ~addr_err;
  assign rd          = access & ~pwrite & ~addr_err;
  assign wr_ctrl     = wr && (blk == 4'd0) && (word == 2'd0);
  assign wr_mlo      = wr && (blk == 4'd0) && (word == 2'd1);
  assign wr_mhi      = wr && (blk == 4'd0) && (word == 2'd2);
  assign wr_stat     = wr && (blk == 4'd0) && (word == 2'd3);
  assign rd_mlo      = rd && (blk == 4'd0) && (word == 2'd1);
  assign unused_addr = ^paddr[1:0];

  assign tick    = ctrl_en & (psc == ctrl_div);
  assign pready  = 1'b1;
  assign irq_req = pending;
  assign pslverr = access & addr_err;
  assign prdata  = rd ? rd_data : 32'h0;

  // CTRL register: EN and DIV; CLR is a pulse and is not stored
  always_ff @(posedge clk) begin
    if (reset) begin
      ctrl_en  <= 1'b0;
      ctrl_div <= '0;
    end else if (wr_ctrl) begin
      ctrl_en  <= pwdata[0];
      ctrl_div <= pwdata[PSC_W+7:8];
    end
  end

  // Prescaler counts 0..DIV while enabled, parked at 0 while disabled
  always_ff @(posedge clk) begin
    if (reset || !ctrl_en) psc <= '0;
    else if (psc >= ctrl_div) psc <= '0;
    else psc <= psc + PSC_ONE;
  end

  // mtime: CLR beats a direct write, which beats the prescaler tick
  always_ff @(posedge clk) begin
    if (reset) mtime <= '0;
    else if (wr_ctrl && pwdata[1]) mtime <= '0;
    else if (wr_mlo) mtime[31:0] <= pwdata;
    else if (wr_mhi) mtime[CNT_W-1:32] <= pwdata[HI_W-1:0];
    else if (tick) mtime <= mtime + CNT_ONE;
  end

  // Reading MTIME_LO snapshots the upper half so a LO/HI pair is coherent
  always_ff @(posedge clk) begin
    if (reset) shadow <= '0;
    else if (rd_mlo) shadow <= mtime[CNT_W-1:32];
  end

  // Unsigned compare of registered mtime against each channel comparator
  always_comb begin
    match = '0;
    for (int i = 0; i < NCH; i++) match[i] = (mtime >= cmp[i]);
  end

  // Per-channel registers, auto-reload and interrupt pending state
  always_ff @(posedge clk) begin
    for (int i = 0; i < NCH; i++) begin
      if (reset) begin
        cmp[i]      <= '1;
        period[i]   <= '0;
        ien[i]      <= 1'b0;
        periodic[i] <= 1'b0;
        pending[i]  <= 1'b0;
      end else begin
        // A bus write to the comparator wins over the auto-reload
        if (wr && ch_ok && ch_sel == 4'(i) && word == 2'd0)
          cmp[i][31:0] <= pwdata;
        else if (wr && ch_ok && ch_sel == 4'(i) && word == 2'd1)
          cmp[i][CNT_W-1:32] <= pwdata[HI_W-1:0];
        else if (periodic[i] && ien[i] && match[i])
          cmp[i] <= cmp[i] + {{HI_W{1'b0}}, period[i]};

        if (wr && ch_ok && ch_sel == 4'(i) && word == 2'd2) begin
          ien[i]      <= pwdata[0];
          periodic[i] <= pwdata[1];
        end
        if (wr && ch_ok && ch_sel == 4'(i) && word == 2'd3)
          period[i] <= pwdata;

        // Level mode tracks the match; periodic mode latches until cleared,
        // and a new match in the same cycle beats ack/W1C
        if (!periodic[i]) pending[i] <= ien[i] & match[i];
        else if (ien[i] & match[i]) pending[i] <= 1'b1;
        else if (irq_ack[i] || (wr_stat && pwdata[i])) pending[i] <= 1'b0;
      end
    end
  end

  // Read data mux for the addressed register
  always_comb begin
    logic [CNT_W-1:0] sel_cmp;
    logic [31:0]      sel_period;
    logic [1:0]       sel_ctl;
    sel_cmp    = '0;
    sel_period = '0;
    sel_ctl    = '0;
    rd_data    = '0;
    for (int i = 0; i < NCH; i++) begin
      if (ch_sel == 4'(i)) begin
        sel_cmp    = cmp[i];
        sel_period = period[i];
        sel_ctl    = {periodic[i], ien[i]};
      end
    end
    if (blk == 4'd0) begin
      case (word)
        2'd0: begin
          rd_data[0]          = ctrl_en;
          rd_data[PSC_W+7:8]  = ctrl_div;
        end
        2'd1:    rd_data              = mtime[31:0];
        2'd2:    rd_data[HI_W-1:0]    = shadow;
        default: rd_data[NCH-1:0]     = pending;
      endcase
    end else if (ch_ok) begin
      case (word)
        2'd0:    rd_data              = sel_cmp[31:0];
        2'd1:    rd_data[HI_W-1:0]    = sel_cmp[CNT_W-1:32];
        2'd2:    rd_data[1:0]         = sel_ctl;
        default: rd_data              = sel_period;
      endcase
    end
  end

endmodule
